// File: rtl/arm_soc_core.sv
`default_nettype none
// arm_soc_core: single-cycle reduced-ARMv4 core with an internal dual-port word data memory.
// Revision 1.0
module arm_soc_core #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  output logic [31:0] PC,
  output logic        MemWrite,
  output logic [31:0] DataAdr,
  output logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [31:0] DbgAdr,
  output logic [31:0] DbgData
);
  localparam int AW = $clog2(DMEM_WORDS);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [0:14];
  logic [3:0]  flags_q, flags_d;  // {N, Z, C, V}
  logic [31:0] mem_q [0:DMEM_WORDS-1];

  logic [3:0]  cond, cmd, rn, rd, rm;
  logic [1:0]  op;
  logic        imm_sel, s_bit, l_bit;
  logic        is_dp, is_mem, is_br;
  logic        is_add, is_sub, is_and, is_orr, is_cmp, dp_wr, arith;
  logic        cond_ok, reg_we, pc_wr, flag_we;
  logic [31:0] pc_plus4, pc_plus8;
  logic [31:0] rn_val, rd_val, rm_val;
  logic [31:0] src_a, src_b, b_eff, result, wb_data;
  logic [32:0] sum;
  logic        sub_sel, ovf;
  logic [AW-1:0] a_idx, b_idx;
  logic        unused_dbg;

  assign cond    = Instr[31:28];
  assign op      = Instr[27:26];
  assign imm_sel = Instr[25];
  assign cmd     = Instr[24:21];
  assign s_bit   = Instr[20];
  assign l_bit   = Instr[20];
  assign rn      = Instr[19:16];
  assign rd      = Instr[15:12];
  assign rm      = Instr[3:0];

  assign is_dp  = (op == 2'b00);
  assign is_mem = (op == 2'b01);
  assign is_br  = (op == 2'b10);

  assign is_add = is_dp && (cmd == CMD_ADD);
  assign is_sub = is_dp && (cmd == CMD_SUB);
  assign is_and = is_dp && (cmd == CMD_AND);
  assign is_orr = is_dp && (cmd == CMD_ORR);
  assign is_cmp = is_dp && (cmd == CMD_CMP);
  assign dp_wr  = is_add || is_sub || is_and || is_orr;
  assign arith  = is_add || is_sub || is_cmp;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  // R15 is not stored; reading it yields the pipeline-visible PC+8.
  always_comb begin
    rn_val = (rn == 4'hF) ? pc_plus8 : regs_q[rn];
    rd_val = (rd == 4'hF) ? pc_plus8 : regs_q[rd];
    rm_val = (rm == 4'hF) ? pc_plus8 : regs_q[rm];
  end

  always_comb begin
    case (cond)
      4'b0000: cond_ok = flags_q[2];
      4'b0001: cond_ok = !flags_q[2];
      4'b0010: cond_ok = flags_q[1];
      4'b0011: cond_ok = !flags_q[1];
      4'b0100: cond_ok = flags_q[3];
      4'b0101: cond_ok = !flags_q[3];
      4'b0110: cond_ok = flags_q[0];
      4'b0111: cond_ok = !flags_q[0];
      4'b1000: cond_ok = flags_q[1] && !flags_q[2];
      4'b1001: cond_ok = !flags_q[1] || flags_q[2];
      4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    src_a = rn_val;
    src_b = {20'd0, Instr[11:0]};
    if (is_dp) begin
      src_b = imm_sel ? {24'd0, Instr[7:0]} : rm_val;
    end else if (is_br) begin
      src_a = pc_plus8;
      src_b = {{6{Instr[23]}}, Instr[23:0], 2'b00};
    end
  end

  // Subtraction is A + ~B + 1 so the carry out is directly NOT borrow.
  assign sub_sel = is_sub || is_cmp;
  assign b_eff   = sub_sel ? ~src_b : src_b;
  assign sum     = {1'b0, src_a} + {1'b0, b_eff} + {32'd0, sub_sel};
  assign ovf     = (src_a[31] == b_eff[31]) && (sum[31] != src_a[31]);

  always_comb begin
    result = sum[31:0];
    if (is_and) result = src_a & src_b;
    else if (is_orr) result = src_a | src_b;
  end

  assign reg_we  = cond_ok && (rd != 4'hF) && (dp_wr || (is_mem && l_bit));
  assign pc_wr   = cond_ok && ((dp_wr && (rd == 4'hF)) || is_br);
  assign flag_we = cond_ok && ((s_bit && dp_wr) || is_cmp);

  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d[3] = result[31];
      flags_d[2] = (result == 32'd0);
      if (arith) begin
        flags_d[1] = sum[32];
        flags_d[0] = ovf;
      end
    end
  end

  assign pc_d    = pc_wr ? result : pc_plus4;
  assign wb_data = is_mem ? ReadData : result;

  assign a_idx      = DataAdr[AW+1:2];
  assign b_idx      = DbgAdr[AW+1:2];
  assign unused_dbg = ^{DbgAdr[31:AW+2], DbgAdr[1:0]};

  assign PC        = pc_q;
  assign DataAdr   = result;
  assign WriteData = rd_val;
  assign ReadData  = mem_q[a_idx];
  assign DbgData   = mem_q[b_idx];
  assign MemWrite  = reset && cond_ok && is_mem && !l_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      if (reg_we) regs_q[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) mem_q[i] <= '0;
    end else if (MemWrite) begin
      mem_q[a_idx] <= WriteData;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arm_soc_core.sv
`default_nettype none
// tb_arm_soc_core: directed program trace checked against hand-computed outputs.
// Revision 1.0
module tb_arm_soc_core;
  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] DbgAdr;
  logic [31:0] DbgData;

  int checks = 0;
  int errors = 0;

  arm_soc_core #(.DMEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .PC(PC), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
    .DbgAdr(DbgAdr), .DbgData(DbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] dbg;
    logic [31:0] pc;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdd;
    logic [31:0] dd;
    logic        chk_adr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] instr, input logic [31:0] dbg, input logic [31:0] pc,
                     input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                     input logic [31:0] rdd, input logic [31:0] dd, input logic chk_adr);
    vec_t v;
    v.instr = instr; v.dbg = dbg; v.pc = pc; v.mw = mw; v.adr = adr;
    v.wd = wd; v.rdd = rdd; v.dd = dd; v.chk_adr = chk_adr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //  instr         dbg     pc     mw  adr           wd      rdd    dd     chk_adr
    add(32'hE2800005, 32'h0,  32'h00, 0, 32'h5,        32'h0,  32'h0, 32'h0, 1); // ADD R0,R0,#5
    add(32'hE2801003, 32'h0,  32'h04, 0, 32'h8,        32'h0,  32'h0, 32'h0, 1); // ADD R1,R0,#3
    add(32'hE0502001, 32'h0,  32'h08, 0, 32'hFFFFFFFD, 32'h0,  32'h0, 32'h0, 1); // SUBS R2,R0,R1
    add(32'h42855001, 32'h0,  32'h0C, 0, 32'h1,        32'h0,  32'h0, 32'h0, 1); // ADDMI R5 (taken)
    add(32'h22866001, 32'h0,  32'h10, 0, 32'h1,        32'h0,  32'h0, 32'h0, 1); // ADDCS R6 (not)
    add(32'hE2867000, 32'h0,  32'h14, 0, 32'h0,        32'h0,  32'h0, 32'h0, 1); // R6 still 0
    add(32'hE2857000, 32'h0,  32'h18, 0, 32'h1,        32'h0,  32'h0, 32'h0, 1); // R5 is 1
    add(32'hE5810004, 32'hC,  32'h1C, 1, 32'hC,        32'h5,  32'h0, 32'h0, 1); // STR R0,[R1,#4]
    add(32'hE5913004, 32'hC,  32'h20, 0, 32'hC,        32'h0,  32'h5, 32'h5, 1); // LDR R3,[R1,#4]
    add(32'hE2833000, 32'hC,  32'h24, 0, 32'h5,        32'h5,  32'h0, 32'h5, 1); // R3 is 5
    add(32'hE3500005, 32'h0,  32'h28, 0, 32'h0,        32'h5,  32'h0, 32'h0, 1); // CMP R0,#5
    add(32'h12844001, 32'h0,  32'h2C, 0, 32'h1,        32'h0,  32'h0, 32'h0, 1); // ADDNE (not)
    add(32'h02844001, 32'h0,  32'h30, 0, 32'h1,        32'h0,  32'h0, 32'h0, 1); // ADDEQ (taken)
    add(32'hE2844000, 32'h0,  32'h34, 0, 32'h1,        32'h1,  32'h0, 32'h0, 1); // R4 is 1
    add(32'hE28F8000, 32'h0,  32'h38, 0, 32'h40,       32'h0,  32'h0, 32'h0, 1); // R15 reads PC+8
    add(32'hEAFFFFFE, 32'h0,  32'h3C, 0, 32'h3C,       32'h44, 32'h0, 32'h0, 1); // B to self
    add(32'hEAFFFFFE, 32'h0,  32'h3C, 0, 32'h3C,       32'h44, 32'h0, 32'h0, 1);
    add(32'h1AFFFFFE, 32'h0,  32'h3C, 0, 32'h3C,       32'h44, 32'h0, 32'h0, 1); // BNE, Z=1: falls
    add(32'hE3500004, 32'h0,  32'h40, 0, 32'h1,        32'h5,  32'h0, 32'h0, 1); // CMP R0,#4: C=1 Z=0
    add(32'h0AFFFFFE, 32'h0,  32'h44, 0, 32'h44,       32'h4C, 32'h0, 32'h0, 1); // BEQ, Z=0: falls
    add(32'hEA000001, 32'h0,  32'h48, 0, 32'h54,       32'h5,  32'h0, 32'h0, 1); // B forward
    add(32'hE28FF008, 32'h0,  32'h54, 0, 32'h64,       32'h5C, 32'h0, 32'h0, 1); // ADD R15,R15,#8
    add(32'hF2800001, 32'h0,  32'h64, 0, 32'h6,        32'h5,  32'h0, 32'h0, 1); // cond NV
    add(32'hE2800000, 32'h0,  32'h68, 0, 32'h5,        32'h5,  32'h0, 32'h0, 1); // R0 still 5
    add(32'hE0109001, 32'h0,  32'h6C, 0, 32'h0,        32'h0,  32'h0, 32'h0, 1); // ANDS R9: Z=1, C kept
    add(32'h228AA001, 32'h0,  32'h70, 0, 32'h1,        32'h0,  32'h0, 32'h0, 1); // ADDCS (taken)
    add(32'h028AA002, 32'h0,  32'h74, 0, 32'h3,        32'h1,  32'h0, 32'h0, 1); // ADDEQ (taken)
    add(32'hE28AB000, 32'h0,  32'h78, 0, 32'h3,        32'h0,  32'h0, 32'h0, 1); // R10 is 3
    add(32'hE1808001, 32'h0,  32'h7C, 0, 32'hD,        32'h40, 32'h5, 32'h0, 1); // ORR R8,R0,R1
    add(32'hE0410000, 32'h0,  32'h80, 0, 32'h3,        32'h5,  32'h0, 32'h0, 1); // SUB R0,R1,R0
    add(32'hEC000000, 32'h0,  32'h84, 0, 32'h0,        32'h3,  32'h0, 32'h0, 0); // op=11 no-op
    add(32'hE2800000, 32'h0,  32'h88, 0, 32'h3,        32'h3,  32'h0, 32'h0, 1); // R0 is 3
    add(32'hE5890100, 32'h0,  32'h8C, 1, 32'h100,      32'h3,  32'h0, 32'h0, 1); // STR wraps to word 0
    add(32'hE2800000, 32'h100,32'h90, 0, 32'h3,        32'h3,  32'h3, 32'h3, 1); // word 0 now 3

    reset  = 1'b0;
    Instr  = 32'hE5810004;
    DbgAdr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_memwrite", {31'd0, MemWrite}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      Instr  = vecs[i].instr;
      DbgAdr = vecs[i].dbg;
      #1;
      chk($sformatf("v%0d_pc", i), PC, vecs[i].pc);
      chk($sformatf("v%0d_memwrite", i), {31'd0, MemWrite}, {31'd0, vecs[i].mw});
      chk($sformatf("v%0d_writedata", i), WriteData, vecs[i].wd);
      chk($sformatf("v%0d_dbgdata", i), DbgData, vecs[i].dd);
      if (vecs[i].chk_adr) begin
        chk($sformatf("v%0d_dataadr", i), DataAdr, vecs[i].adr);
        chk($sformatf("v%0d_readdata", i), ReadData, vecs[i].rdd);
      end
      @(negedge clk);
    end

    // Reset asserted in the middle of a store cycle at PC=0x94.
    Instr  = 32'hE5810008;
    DbgAdr = 32'hC;
    #1;
    chk("mid_pc", PC, 32'h94);
    chk("mid_memwrite", {31'd0, MemWrite}, 32'h1);
    chk("mid_dataadr", DataAdr, 32'h10);
    chk("mid_dbg_before", DbgData, 32'h5);
    #1 reset = 1'b0;
    #1;
    chk("rst_pc_immediate", PC, 32'h0);
    chk("rst_memwrite", {31'd0, MemWrite}, 32'h0);
    chk("rst_mem_cleared", DbgData, 32'h0);
    @(negedge clk);
    DbgAdr = 32'h10;
    #1;
    chk("rst_no_store", DbgData, 32'h0);
    chk("rst_pc_held", PC, 32'h0);
    reset  = 1'b1;
    Instr  = 32'hE2800000;
    DbgAdr = 32'h0;
    #1;
    chk("post_pc", PC, 32'h0);
    chk("post_r0_cleared", DataAdr, 32'h0);
    chk("post_word0_cleared", DbgData, 32'h0);
    @(negedge clk);
    #1;
    chk("post_pc_step", PC, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arm_soc_core.md
Name: arm_soc_core

Overview:
- Single-cycle 32-bit processor for a reduced ARMv4 subset, with an internal dual-port word data memory.
- Instructions come from an external instruction store: the block presents PC and receives Instr combinationally in the same cycle.
- Memory port A serves loads/stores; port B is an independent read-only port for inspecting memory contents.

Parameters:
- DMEM_WORDS, 64, data memory depth in 32-bit words (power of two).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Instr  input  32  instruction fetched at PC
- PC  output  32  current program counter (byte address)
- MemWrite  output  1  store executing this cycle
- DataAdr  output  32  ALU result / port A byte address
- WriteData  output  32  store data (Rd value)
- ReadData  output  32  port A read data
- DbgAdr  input  32  port B byte address
- DbgData  output  32  port B read data

Behaviour:
- Reset (reset=0), asynchronous:
  - PC=0; R0–R14=0; NZCV=0000; all dmem words=0.
  - MemWrite=0 while reset is held.
- Single-cycle timing:
  - Decode, ALU, register/memory reads and next-PC are combinational.
  - PC, register file, flags and dmem update on the rising clk edge only.
  - A rising edge is ignored while reset=0.
- Next PC: PC+4, unless a taken branch or a data-processing write to R15 occurs.
- R15 read as an operand returns PC+8.
- Condition field Instr[31:28]: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL(1110).
  - 1111 behaves as never.
  - A failed condition suppresses the register write, flag write, memory write and branch; PC advances by 4.
- op Instr[27:26]=00, data processing:
  - I=Instr[25]; cmd=Instr[24:21]; S=Instr[20]; Rn=[19:16]; Rd=[15:12].
  - Src2 = I ? zero-extended Instr[7:0] (no rotation) : register Instr[3:0] (shift field ignored).
  - cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR: write Rd.
  - cmd 1010 CMP: SUB with no Rd write; flags written regardless of S.
  - Any other cmd: no-op.
- Flags (written when S=1 and the condition passes):
  - N = result[31]; Z = (result==0).
  - ADD/SUB/CMP also update C and V. SUB carry = NOT borrow (A+~B+1). V = signed overflow.
  - AND/ORR leave C and V unchanged.
- op=01, memory:
  - Address = Rn + zero-extended Instr[11:0]; bits 25 and 23:21 ignored.
  - L=Instr[20]=1 is LDR: Rd ← dmem word.
  - L=0 is STR: dmem ← Rd at the clock edge, MemWrite=1 that cycle.
- op=10, branch B: PC ← PC+8 + (sign-extended Instr[23:0] << 2). Bit 24 (link) ignored.
- op=11: no-op.
- Memory:
  - Word index = address[log2(DMEM_WORDS)+1:2]; higher bits wrap; low 2 bits ignored (no unaligned support).
  - Both ports read combinationally.
  - A read on the same cycle as a write to the same word returns the old value; the new value is visible next cycle.
- Outputs are always driven:
  - DataAdr = ALU result.
  - WriteData = Rd register value.
  - ReadData = mem[DataAdr].
- Arithmetic is 32-bit modular; overflow only affects flags.

Test Plan:
1. Reset: hold reset=0 over two clocks, release -> PC=0, MemWrite=0; after the first edge PC=4.
2. Immediate ALU: Instr E3A00000-style ADD R0=R15? Instead use E2800005 (ADD R0,R0,#5) then E2801003 (ADD R1,R0,#3) -> DataAdr=8 on the second instruction; E0502001 (SUBS R2,R0,R1) sets N=1, C=0, Z=0.
3. Store/load: with R1=8 and R0=5, STR R0,[R1,#4] (E5810004) -> MemWrite=1, DataAdr=0xC, WriteData=5; then DbgAdr=0xC gives DbgData=5; LDR R3,[R1,#4] (E5913004) -> R3=5.
4. Conditional: CMP R0,#5 (E3500005) -> Z=1; ADDNE R4,R4,#1 (12844001) leaves R4=0; ADDEQ increments R4 to 1.
5. Branch: at PC=0x10, B with imm24=0xFFFFFE (EAFFFFFE) -> next PC=0x10; BEQ with Z=0 -> PC=0x14.
6. Reset mid-program: assert reset during a STR cycle -> no memory write, PC=0 immediately, memory read back as 0.
